// File: rtl/can_lg_pkg.sv
// Shared types and constants for the CAN multiplexed-bus register target.
package can_lg_pkg;

  // Default watchdog limit in clk_i cycles.
  localparam int unsigned TimeoutCycDefault = 256;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StArmed,
    StWdone,
    StRdata
  } can_lg_state_e;

endpackage

// File: rtl/can_lg_wdog.sv
// Access watchdog: counts cycles spent outside IDLE and fires once at the limit.
module can_lg_wdog #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [CntW-1:0] r_cnt;
  logic            w_expire;

  // The limit-th non-idle cycle is the one whose closing edge fires.
  assign w_expire = active_i && (r_cnt == CntW'(TIMEOUT_CYC - 1));
  assign expire_o = w_expire;

  // Counter clears while idle and after firing, otherwise advances.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (!active_i || w_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/can_lg_target.sv
// Register target for a multiplexed ALE/RD/WR host bus.
// Optional watchdog enabled by defining CAN_LG_TIMEOUT_EN.
module can_lg_target
  import can_lg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_can_i,
  input  logic       ale_i,
  input  logic       wr_i,
  input  logic       rd_i,
  input  logic [7:0] port_0_i,
  output logic [7:0] port_0_o,
  output logic       port_0_oe,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       err_o
);

  can_lg_state_e r_state, w_state_nxt;
  logic [7:0]    r_addr, w_addr_nxt;
  logic [7:0]    r_wdata, w_wdata_nxt;
  logic [7:0]    r_rd_hold, w_rd_hold_nxt;
  logic          r_we, w_we_nxt;
  logic          r_re, w_re_nxt;
  logic          r_err, w_err_nxt;
  logic          w_tmo;

`ifdef CAN_LG_TIMEOUT_EN
  can_lg_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (r_state != StIdle),
    .expire_o (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  // Next-state, address/data capture and strobe pulse generation.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_rd_hold_nxt = r_rd_hold;
    w_we_nxt      = 1'b0;
    w_re_nxt      = 1'b0;
    w_err_nxt     = 1'b0;

    // Address follows the bus for as long as ALE is held; last value wins.
    if (cs_can_i && ale_i &&
        (r_state == StIdle || r_state == StAddr || r_state == StArmed)) begin
      w_addr_nxt = port_0_i;
    end

    unique case (r_state)
      StIdle: begin
        if (cs_can_i && ale_i) w_state_nxt = StAddr;
      end
      StAddr: begin
        // Prefetch so read data is ready on the first ARMED cycle.
        w_rd_hold_nxt = reg_rdata_i;
        if (!cs_can_i)   w_state_nxt = StIdle;
        else if (!ale_i) w_state_nxt = StArmed;
      end
      StArmed: begin
        w_rd_hold_nxt = reg_rdata_i;
        if (!cs_can_i) begin
          w_state_nxt = StIdle;
        end else if (ale_i) begin
          w_state_nxt = StAddr;
        end else if (wr_i && rd_i) begin
          w_state_nxt = StIdle;
          w_err_nxt   = 1'b1;
        end else if (wr_i) begin
          w_state_nxt = StWdone;
          w_wdata_nxt = port_0_i;
          w_we_nxt    = 1'b1;
        end else if (rd_i) begin
          // Hold the value already on the bus for the whole read.
          w_state_nxt   = StRdata;
          w_rd_hold_nxt = r_rd_hold;
          w_re_nxt      = 1'b1;
        end
      end
      StWdone: begin
        if (!cs_can_i || !wr_i) w_state_nxt = StIdle;
      end
      StRdata: begin
        if (!cs_can_i || !rd_i) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

    // Watchdog expiry wins over any strobe captured on the same edge.
    if (w_tmo) begin
      w_state_nxt = StIdle;
      w_we_nxt    = 1'b0;
      w_re_nxt    = 1'b0;
      w_err_nxt   = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_rd_hold <= 8'h00;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rd_hold <= w_rd_hold_nxt;
      r_we      <= w_we_nxt;
      r_re      <= w_re_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Bus drive is combinational so data appears in the cycle RD rises.
  assign port_0_oe = cs_can_i && rd_i && !rst_i &&
                     (r_state == StArmed || r_state == StRdata);
  assign port_0_o    = r_rd_hold;
  assign reg_addr_o  = r_addr;
  assign reg_wdata_o = r_wdata;
  assign reg_we_o    = r_we;
  assign reg_re_o    = r_re;
  assign err_o       = r_err;

endmodule

// File: tb/tb_can_lg_target.sv
// Self-checking bench for can_lg_target: directed cases plus randomized transactions.
module tb_can_lg_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_can, ale, wr, rd;
  logic [7:0] p0_in;
  logic [7:0] port_0_o;
  logic       port_0_oe;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic       reg_we_o, reg_re_o, err_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Register file behind the target; unwritten locations read addr ^ 8'hC1.
  bit [7:0] rf_mem   [256];
  bit       rf_valid [256];

  // Bench-side expectation of register contents, updated from issued writes.
  bit [7:0] model_mem   [256];
  bit       model_valid [256];

  // Pulse counters sampled away from the active edge.
  int we_total  = 0;
  int re_total  = 0;
  int err_total = 0;

  always #5 clk = ~clk;

  can_lg_target #(
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cs_can_i    (cs_can),
    .ale_i       (ale),
    .wr_i        (wr),
    .rd_i        (rd),
    .port_0_i    (p0_in),
    .port_0_o    (port_0_o),
    .port_0_oe   (port_0_oe),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_rdata_i (reg_rdata_i),
    .err_o       (err_o)
  );

  assign reg_rdata_i = rf_valid[reg_addr_o] ? rf_mem[reg_addr_o] : (reg_addr_o ^ 8'hC1);

  always @(posedge clk) begin
    if (reg_we_o) begin
      rf_mem[reg_addr_o]   <= reg_wdata_o;
      rf_valid[reg_addr_o] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reg_we_o) we_total++;
    if (reg_re_o) re_total++;
    if (err_o)    err_total++;
  end

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    return model_valid[a] ? model_mem[a] : (a ^ 8'hC1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_bus();
    cs_can = 1'b0; ale = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  // Address phase; returns on a falling edge with the target armed.
  task automatic do_ale(input logic [7:0] a);
    @(negedge clk);
    cs_can = 1'b1; ale = 1'b1; p0_in = a;
    @(negedge clk);
    ale = 1'b0; p0_in = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int we0 = we_total;
    int re0 = re_total;
    do_ale(a);
    p0_in = d; wr = 1'b1;
    @(negedge clk);
    check("wr_we_pulse", reg_we_o, 1'b1);
    check("wr_addr", reg_addr_o, a);
    check("wr_data", reg_wdata_o, d);
    idle_bus();
    @(negedge clk);
    @(negedge clk);
    check("wr_we_count", we_total - we0, 1);
    check("wr_re_count", re_total - re0, 0);
    model_mem[a]   = d;
    model_valid[a] = 1'b1;
  endtask

  task automatic do_read(input logic [7:0] a);
    int we0 = we_total;
    int re0 = re_total;
    do_ale(a);
    rd = 1'b1;
    #1;
    check("rd_oe_first", port_0_oe, 1'b1);
    check("rd_data_first", port_0_o, exp_rd(a));
    @(negedge clk);
    check("rd_re_pulse", reg_re_o, 1'b1);
    check("rd_data_held", port_0_o, exp_rd(a));
    idle_bus();
    #1;
    check("rd_oe_release", port_0_oe, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rd_re_count", re_total - re0, 1);
    check("rd_we_count", we_total - we0, 0);
  endtask

  task automatic do_collide(input logic [7:0] a);
    int we0 = we_total;
    int re0 = re_total;
    int er0 = err_total;
    do_ale(a);
    rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    check("col_err_pulse", err_o, 1'b1);
    check("col_idle_no_oe", port_0_oe, 1'b0);
    idle_bus();
    @(negedge clk);
    @(negedge clk);
    check("col_err_count", err_total - er0, 1);
    check("col_we_count", we_total - we0, 0);
    check("col_re_count", re_total - re0, 0);
  endtask

  // Chip select drops after the address; later strobes must be ignored.
  task automatic do_abort(input logic [7:0] a);
    int we0 = we_total;
    int re0 = re_total;
    do_ale(a);
    cs_can = 1'b0;
    @(negedge clk);
    wr = 1'b1; p0_in = 8'($urandom);
    @(negedge clk);
    cs_can = 1'b1;
    @(negedge clk);
    rd = 1'b1; wr = 1'b0;
    #1;
    check("abort_no_oe", port_0_oe, 1'b0);
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    check("abort_we_count", we_total - we0, 0);
    check("abort_re_count", re_total - re0, 0);
  endtask

  initial begin
    logic [7:0] a, d;
    int er0;
    rst = 1'b1;
    p0_in = 8'h00;
    idle_bus();
    repeat (2) @(negedge clk);
    check("rst_port_0_o", port_0_o, 8'h00);
    check("rst_oe", port_0_oe, 1'b0);
    check("rst_addr", reg_addr_o, 8'h00);
    check("rst_wdata", reg_wdata_o, 8'h00);
    check("rst_we", reg_we_o, 1'b0);
    check("rst_re", reg_re_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    do_read(8'h02);
    do_write(8'h0A, 8'h55);
    do_read(8'h0A);
    do_collide(8'h04);
    do_abort(8'h0B);
    do_write(8'h10, 8'hA7);
    do_read(8'h10);

    // Long stall in ARMED.
    er0 = err_total;
    do_ale(8'h02);
    repeat (20) @(negedge clk);
`ifdef CAN_LG_TIMEOUT_EN
    check("tmo_err_count", err_total - er0, 1);
    rd = 1'b1;
    #1;
    check("tmo_idle_no_oe", port_0_oe, 1'b0);
`else
    check("stall_no_err", err_total - er0, 0);
    rd = 1'b1;
    #1;
    check("stall_still_armed", port_0_oe, 1'b1);
    check("stall_data", port_0_o, exp_rd(8'h02));
`endif
    @(negedge clk);
    idle_bus();
    repeat (2) @(negedge clk);

    // Reset in the middle of a read.
    do_ale(8'h0A);
    rd = 1'b1;
    @(negedge clk);
    check("mid_rd_oe", port_0_oe, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_oe", port_0_oe, 1'b0);
    check("mid_rst_p0", port_0_o, 8'h00);
    check("mid_rst_addr", reg_addr_o, 8'h00);
    check("mid_rst_wdata", reg_wdata_o, 8'h00);
    check("mid_rst_we", reg_we_o, 1'b0);
    check("mid_rst_re", reg_re_o, 1'b0);
    check("mid_rst_err", err_o, 1'b0);
    @(negedge clk);
    idle_bus();
    rst = 1'b0;
    @(negedge clk);

    // Randomized transactions over a small address window so reads hit writes.
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 7)) + 8'h20;
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 1: do_write(a, d);
        2:    do_read(a);
        default: begin
          if ($urandom_range(0, 1) == 0) do_collide(a);
          else do_abort(a);
        end
      endcase
    end
    for (int i = 0; i < 8; i++) do_read(8'h20 + 8'(i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/can_lg_target.md
CAN_LG_TARGET -- requirements
Module: can_lg_target

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, meaning the watchdog limit in clk_i cycles (used only when CAN_LG_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk_i  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cs_can_i  input  1  chip select from host.
REQ-005 SHALL have port ale_i  input  1  address latch enable.
REQ-006 SHALL have port wr_i  input  1  write strobe.
REQ-007 SHALL have port rd_i  input  1  read strobe.
REQ-008 SHALL have port port_0_i  input  8  sampled multiplexed address/data bus.
REQ-009 SHALL have port port_0_o  output  8  read data driven toward the bus.
REQ-010 SHALL have port port_0_oe  output  1  bus drive enable (1 = target drives).
REQ-011 SHALL have port reg_addr_o  output  8  latched register address.
REQ-012 SHALL have port reg_wdata_o  output  8  captured write data.
REQ-013 SHALL have port reg_we_o  output  1  one-cycle write pulse.
REQ-014 SHALL have port reg_re_o  output  1  one-cycle read-side-effect pulse.
REQ-015 SHALL have port reg_rdata_i  input  8  combinational register read data at reg_addr_o.
REQ-016 SHALL have port err_o  output  1  one-cycle protocol-error pulse.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, ARMED, WDONE, RDATA.
REQ-018 IDLE/ARMED: cs_can_i&ale_i -> ADDR; reg_addr_o <= port_0_i on every edge while ale_i=1 (last value wins).
REQ-019 ADDR: ale_i=0 with cs_can_i=1 -> ARMED; cs_can_i=0 -> IDLE.
REQ-020 ARMED: rd_hold <= reg_rdata_i every cycle (prefetch, one-cycle latency from address latch).
REQ-021 ARMED: cs&wr_i&!rd_i -> WDONE; reg_wdata_o <= port_0_i; reg_we_o=1 the following cycle only.
REQ-022 ARMED: cs&rd_i&!wr_i -> RDATA; reg_re_o=1 the following cycle only; rd_hold frozen.
REQ-023 port_0_oe SHALL be combinational cs_can_i&rd_i&(state ARMED or RDATA); port_0_o = rd_hold, so data is valid in the same cycle rd_i rises.
REQ-024 WDONE/RDATA: strobe deasserted or cs_can_i=0 -> IDLE.
REQ-025 rd_i&wr_i both high in ARMED: no reg_we_o/reg_re_o, err_o pulse, -> IDLE.
REQ-026 cs_can_i=0 in any non-IDLE state: -> IDLE next edge; reg_we_o/reg_re_o SHALL NOT issue unless the strobe was already captured.
REQ-027 wr_i/rd_i without cs_can_i or outside ARMED SHALL be ignored.

Reset
REQ-028 On rst_i: state=IDLE; port_0_o, reg_addr_o, reg_wdata_o, rd_hold = 8'h00; port_0_oe, reg_we_o, reg_re_o, err_o = 0.
REQ-029 rst_i mid-access SHALL abort immediately; port_0_oe=0 while rst_i=1.

Configuration
REQ-030 CAN_LG_TIMEOUT_EN defined: counter clears in IDLE, increments in other states; reaching TIMEOUT_CYC -> IDLE, err_o pulse, counter cleared.
REQ-031 CAN_LG_TIMEOUT_EN undefined: no counter; non-IDLE states persist indefinitely.

Structure
REQ-032 Package can_lg_pkg SHALL hold the state enum typedef and the TIMEOUT_CYC default constant.
REQ-033 Watchdog SHALL be sub-module can_lg_wdog, instantiated only under CAN_LG_TIMEOUT_EN.

Verification
REQ-034 Write: ALE addr 8'h0A, WR data 8'h55 -> reg_we_o one pulse with reg_addr_o=8'h0A, reg_wdata_o=8'h55.
REQ-035 Read: reg_rdata_i=8'hC3 at 8'h02, ALE then RD -> port_0_oe=1 and port_0_o=8'hC3 in RD cycle, one reg_re_o pulse.
REQ-036 rd_i&wr_i together after ALE 8'h04 -> err_o one pulse, no reg_we_o/reg_re_o, state IDLE.
REQ-037 cs_can_i drops after ALE, before WR -> no reg_we_o; next write to 8'h10 completes normally.
REQ-038 CAN_LG_TIMEOUT_EN, TIMEOUT_CYC=16: ALE then idle 16 cycles -> err_o pulse, IDLE; without macro no err_o.
REQ-039 rst_i asserted during RDATA -> port_0_oe=0 immediately, all outputs at reset values.
